// File: rtl/sign_extractor.sv
// Sign extractor: pulls mask-marked sign bits out of a byte stream MSB-first and emits a
// run-length token stream, a sign-bit stream and the cleaned data bytes.
module sign_extractor #(
    parameter int unsigned RUN_MAX = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic [7:0] data_in,
    input  logic [7:0] mask_in,
    input  logic       data_empty,
    input  logic       mask_empty,
    input  logic       flush_req,
    input  logic       data_full,
    input  logic       cnt_full,
    input  logic       sign_full,
    output logic       data_rd,
    output logic       mask_rd,
    output logic [7:0] data_out,
    output logic       data_wr,
    output logic [7:0] cnt_out,
    output logic       cnt_wr,
    output logic       sign_out,
    output logic       sign_wr,
    output logic       flush_done
);

    localparam int unsigned RUN_W = 7;
    localparam int unsigned SUM_W = 8;
    localparam int unsigned PTR_W = 3;
    localparam logic [SUM_W-1:0] RUN_MAX_S = SUM_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] RUN_MAX_R = RUN_W'(RUN_MAX);

    typedef struct packed {
        logic             sign_next;
        logic [RUN_W-1:0] run;
    } token_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCAN  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             flush_pend_q, flush_pend_d;
    logic [7:0]       data_reg_q, data_reg_d;
    logic [7:0]       mask_reg_q, mask_reg_d;
    logic [7:0]       mask_orig_q, mask_orig_d;

    logic             found_c;
    logic [PTR_W-1:0] pos_c;
    logic [3:0]       dist_c;
    logic [SUM_W-1:0] sum_c;

    logic             pop_c;
    token_t           tok_c;
    logic             tok_wr_c;
    logic             sgn_c;
    logic             sgn_wr_c;
    logic             dat_wr_c;
    logic             done_c;

    // Highest remaining sign position at or below the scan pointer.
    always_comb begin
        found_c = 1'b0;
        pos_c   = '0;
        for (int i = 0; i < 8; i++) begin
            if (mask_reg_q[i] && (PTR_W'(i) <= ptr_q)) begin
                found_c = 1'b1;
                pos_c   = PTR_W'(i);
            end
        end
    end

    assign dist_c = found_c ? 4'(ptr_q - pos_c) : (4'(ptr_q) + 4'd1);
    assign sum_c  = SUM_W'(run_q) + SUM_W'(dist_c);

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        ptr_d        = ptr_q;
        flush_pend_d = flush_pend_q | flush_req;
        data_reg_d   = data_reg_q;
        mask_reg_d   = mask_reg_q;
        mask_orig_d  = mask_orig_q;
        pop_c        = 1'b0;
        tok_c        = '0;
        tok_wr_c     = 1'b0;
        sgn_c        = 1'b0;
        sgn_wr_c     = 1'b0;
        dat_wr_c     = 1'b0;
        done_c       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!data_empty && !mask_empty) begin
                    pop_c   = 1'b1;
                    state_d = LOAD;
                end else if (flush_pend_q && data_empty && mask_empty) begin
                    state_d = FLUSH;
                end
            end

            LOAD: begin
                data_reg_d  = data_in;
                mask_reg_d  = mask_in;
                mask_orig_d = mask_in;
                ptr_d       = PTR_W'(7);
                state_d     = SCAN;
            end

            SCAN: begin
                if (found_c && (sum_c <= RUN_MAX_S)) begin
                    // Sign token; the last sign at bit 0 also retires the byte.
                    if (!cnt_full && !sign_full && ((pos_c != '0) || !data_full)) begin
                        tok_c      = '{sign_next: 1'b1, run: RUN_W'(sum_c)};
                        tok_wr_c   = 1'b1;
                        sgn_c      = data_reg_q[pos_c];
                        sgn_wr_c   = 1'b1;
                        run_d      = '0;
                        mask_reg_d[pos_c] = 1'b0;
                        if (pos_c == '0) begin
                            dat_wr_c = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            ptr_d = pos_c - PTR_W'(1);
                        end
                    end
                end else if (found_c) begin
                    // Saturated run ahead of a sign; the sign itself goes out next cycle.
                    if (!cnt_full) begin
                        tok_c    = '{sign_next: 1'b0, run: RUN_MAX_R};
                        tok_wr_c = 1'b1;
                        run_d    = RUN_W'(sum_c - RUN_MAX_S);
                        ptr_d    = pos_c;
                    end
                end else if (sum_c > RUN_MAX_S) begin
                    if (!cnt_full && !data_full) begin
                        tok_c    = '{sign_next: 1'b0, run: RUN_MAX_R};
                        tok_wr_c = 1'b1;
                        run_d    = RUN_W'(sum_c - RUN_MAX_S);
                        dat_wr_c = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    if (!data_full) begin
                        run_d    = RUN_W'(sum_c);
                        dat_wr_c = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            FLUSH: begin
                if (run_q != '0) begin
                    if (!cnt_full) begin
                        tok_c        = '{sign_next: 1'b0, run: run_q};
                        tok_wr_c     = 1'b1;
                        done_c       = 1'b1;
                        run_d        = '0;
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end
                end else begin
                    done_c       = 1'b1;
                    flush_pend_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            run_q        <= '0;
            ptr_q        <= PTR_W'(7);
            flush_pend_q <= 1'b0;
            data_reg_q   <= '0;
            mask_reg_q   <= '0;
            mask_orig_q  <= '0;
        end else if (clk_en) begin
            state_q      <= state_d;
            run_q        <= run_d;
            ptr_q        <= ptr_d;
            flush_pend_q <= flush_pend_d;
            data_reg_q   <= data_reg_d;
            mask_reg_q   <= mask_reg_d;
            mask_orig_q  <= mask_orig_d;
        end
    end

    // FIFO strobes follow the decision logic directly so pushes land in the same cycle.
    assign data_rd    = clk_en & pop_c;
    assign mask_rd    = clk_en & pop_c;
    assign data_wr    = clk_en & dat_wr_c;
    assign cnt_wr     = clk_en & tok_wr_c;
    assign sign_wr    = clk_en & sgn_wr_c;
    assign flush_done = clk_en & done_c;
    assign cnt_out    = tok_c;
    assign sign_out   = sgn_c;
    assign data_out   = data_reg_q & ~mask_orig_q;

endmodule

// File: tb/tb_sign_extractor.sv
// Scoreboard bench for sign_extractor: directed bytes with hand-derived token, sign and data streams.
module tb_sign_extractor;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       clk_en     = 1'b1;
    logic [7:0] data_in    = '0;
    logic [7:0] mask_in    = '0;
    logic       data_empty = 1'b1;
    logic       mask_empty = 1'b1;
    logic       flush_req  = 1'b0;
    logic       data_full  = 1'b0;
    logic       cnt_full   = 1'b0;
    logic       sign_full  = 1'b0;
    logic       data_rd, mask_rd, data_wr, cnt_wr, sign_wr, sign_out, flush_done;
    logic [7:0] data_out, cnt_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] src_q[$];
    logic        force_mask_empty = 1'b0;
    logic        pop_pend = 1'b0;
    logic [15:0] src_ent;

    logic [7:0] exp_cnt_q[$];
    logic       exp_sign_q[$];
    logic [7:0] exp_data_q[$];
    int         exp_data_tok_q[$];
    int         exp_done_tok_q[$];
    int         exp_tok_total = 0;
    int         tok_seen = 0;

    logic [7:0] e_byte;
    logic       e_bit;
    int         e_tok;

    sign_extractor #(.RUN_MAX(127)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .data_in    (data_in),
        .mask_in    (mask_in),
        .data_empty (data_empty),
        .mask_empty (mask_empty),
        .flush_req  (flush_req),
        .data_full  (data_full),
        .cnt_full   (cnt_full),
        .sign_full  (sign_full),
        .data_rd    (data_rd),
        .mask_rd    (mask_rd),
        .data_out   (data_out),
        .data_wr    (data_wr),
        .cnt_out    (cnt_out),
        .cnt_wr     (cnt_wr),
        .sign_out   (sign_out),
        .sign_wr    (sign_wr),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    // Source FIFO model: a pop seen before the edge presents the entry just after it.
    always begin
        @(negedge clk);
        pop_pend = data_rd;
        @(posedge clk);
        #1;
        if (pop_pend && src_q.size() > 0) begin
            src_ent = src_q.pop_front();
            data_in = src_ent[15:8];
            mask_in = src_ent[7:0];
        end
        data_empty = (src_q.size() == 0);
        mask_empty = (src_q.size() == 0) || force_mask_empty;
    end

    // Monitor: pops expectations whenever the DUT writes a sink FIFO.
    always @(negedge clk) begin
        if (rst) begin
            if (data_rd || mask_rd) begin
                checks++;
                if (data_rd !== mask_rd || data_empty || mask_empty) begin
                    errors++;
                    $display("FAIL pop_rule: data_rd=%b mask_rd=%b data_empty=%b mask_empty=%b, required paired pop of non-empty FIFOs",
                             data_rd, mask_rd, data_empty, mask_empty);
                end
            end
            if (!clk_en) begin
                checks++;
                if ({data_rd, mask_rd, data_wr, cnt_wr, sign_wr, flush_done} !== 6'b0) begin
                    errors++;
                    $display("FAIL clk_en_gate: strobes=%b, required 000000",
                             {data_rd, mask_rd, data_wr, cnt_wr, sign_wr, flush_done});
                end
            end
            if (cnt_wr || sign_wr) begin
                checks++;
                if (sign_wr !== (cnt_wr && cnt_out[7])) begin
                    errors++;
                    $display("FAIL sign_pairing: sign_wr=%b cnt_wr=%b cnt_out=%h", sign_wr, cnt_wr, cnt_out);
                end
            end
            if (cnt_wr) begin
                tok_seen++;
                checks++;
                if (cnt_full) begin
                    errors++;
                    $display("FAIL cnt_overflow: cnt_wr=1 while cnt_full=1, required no write");
                end
                checks++;
                if (exp_cnt_q.size() == 0) begin
                    errors++;
                    $display("FAIL cnt_token: got %h, required no token", cnt_out);
                end else begin
                    e_byte = exp_cnt_q.pop_front();
                    if (cnt_out !== e_byte) begin
                        errors++;
                        $display("FAIL cnt_token: got %h, required %h", cnt_out, e_byte);
                    end
                end
            end
            if (sign_wr) begin
                checks++;
                if (sign_full) begin
                    errors++;
                    $display("FAIL sign_overflow: sign_wr=1 while sign_full=1, required no write");
                end
                checks++;
                if (exp_sign_q.size() == 0) begin
                    errors++;
                    $display("FAIL sign_bit: got %b, required no sign", sign_out);
                end else begin
                    e_bit = exp_sign_q.pop_front();
                    if (sign_out !== e_bit) begin
                        errors++;
                        $display("FAIL sign_bit: got %b, required %b", sign_out, e_bit);
                    end
                end
            end
            if (data_wr) begin
                checks++;
                if (data_full) begin
                    errors++;
                    $display("FAIL data_overflow: data_wr=1 while data_full=1, required no write");
                end
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL data_byte: got %h, required no byte", data_out);
                end else begin
                    e_byte = exp_data_q.pop_front();
                    e_tok  = exp_data_tok_q.pop_front();
                    if (data_out !== e_byte || tok_seen != e_tok) begin
                        errors++;
                        $display("FAIL data_byte: got %h after %0d tokens, required %h after %0d tokens",
                                 data_out, tok_seen, e_byte, e_tok);
                    end
                end
            end
            if (flush_done) begin
                checks++;
                if (exp_done_tok_q.size() == 0) begin
                    errors++;
                    $display("FAIL flush_done: unexpected pulse after %0d tokens", tok_seen);
                end else begin
                    e_tok = exp_done_tok_q.pop_front();
                    if (tok_seen != e_tok) begin
                        errors++;
                        $display("FAIL flush_done: pulse after %0d tokens, required after %0d", tok_seen, e_tok);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_tok(input logic [7:0] t, input logic s);
        exp_cnt_q.push_back(t);
        if (t[7]) exp_sign_q.push_back(s);
        exp_tok_total++;
    endtask

    task automatic exp_dat(input logic [7:0] v);
        exp_data_q.push_back(v);
        exp_data_tok_q.push_back(exp_tok_total);
    endtask

    task automatic exp_done();
        exp_done_tok_q.push_back(exp_tok_total);
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] m);
        src_q.push_back({d, m});
    endtask

    task automatic flush();
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_cnt_q.size() + exp_sign_q.size() + exp_data_q.size() + exp_done_tok_q.size()) != 0
               && n < 2000) begin
            tick(1);
            n++;
        end
        tick(4);
        checks++;
        if ((exp_cnt_q.size() + exp_sign_q.size() + exp_data_q.size() + exp_done_tok_q.size()) != 0) begin
            errors++;
            $display("FAIL %s: %0d tokens, %0d signs, %0d bytes, %0d flushes outstanding, required none",
                     name, exp_cnt_q.size(), exp_sign_q.size(), exp_data_q.size(), exp_done_tok_q.size());
        end
    endtask

    task automatic chk_quiet(input string name);
        logic [24:0] act;
        act = {data_rd, mask_rd, data_wr, cnt_wr, sign_wr, flush_done, sign_out, data_out, cnt_out};
        checks++;
        if (act !== 25'h0) begin
            errors++;
            $display("FAIL %s: outputs=%h, required 0000000", name, act);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        tick(3);
        chk_quiet("reset_outputs");
        rst = 1'b1;
        tick(2);
        chk_quiet("idle_after_reset");

        // A5 with no signs: run of 8 held until flush; data FIFO full stalls the byte.
        exp_dat(8'hA5);
        exp_tok(8'h08, 1'b0);
        exp_done();
        push(8'hA5, 8'h00);
        data_full = 1'b1;
        tick(2);
        flush();
        tick(3);
        data_full = 1'b0;
        drain("case_a5");

        // Sign at bit 7, then seven plain bits remain in the run.
        exp_tok(8'h80, 1'b1);
        exp_dat(8'h00);
        exp_tok(8'h07, 1'b0);
        exp_done();
        push(8'h80, 8'h80);
        sign_full = 1'b1;
        tick(5);
        sign_full = 1'b0;
        tick(2);
        flush();
        drain("case_80");

        // Two signs: bit 4 (1) and bit 0 (0); run ends at 0 so flush emits nothing.
        exp_tok(8'h83, 1'b1);
        exp_tok(8'h83, 1'b0);
        exp_dat(8'h4A);
        exp_done();
        push(8'h5A, 8'h11);
        tick(2);
        flush();
        drain("case_5a");

        // Same byte with the token FIFO full for five cycles mid-byte.
        exp_tok(8'h83, 1'b1);
        exp_tok(8'h83, 1'b0);
        exp_dat(8'h4A);
        exp_done();
        push(8'h5A, 8'h11);
        tick(3);
        cnt_full = 1'b1;
        tick(5);
        cnt_full = 1'b0;
        tick(2);
        flush();
        drain("case_5a_cnt_full");

        // 16 plain bytes saturate at 127 with carry 1, then a sign at bit 6.
        for (int i = 0; i < 16; i++) begin
            if (i == 15) exp_tok(8'h7F, 1'b0);
            exp_dat(8'((i * 16) + 1));
        end
        exp_tok(8'h82, 1'b1);
        exp_dat(8'h83);
        exp_tok(8'h06, 1'b0);
        exp_done();
        for (int i = 0; i < 16; i++) push(8'((i * 16) + 1), 8'h00);
        push(8'hC3, 8'h40);
        tick(6);
        clk_en = 1'b0;
        tick(3);
        clk_en = 1'b1;
        force_mask_empty = 1'b1;
        tick(6);
        force_mask_empty = 1'b0;
        tick(2);
        flush();
        drain("case_saturate");

        // Run reaches exactly 127, then a sign 7 bits on forces the split-run path.
        exp_tok(8'h80, 1'b0);
        exp_dat(8'h00);
        for (int i = 0; i < 15; i++) exp_dat(8'h3C);
        exp_tok(8'h7F, 1'b0);
        exp_tok(8'h87, 1'b1);
        exp_dat(8'h00);
        exp_done();
        push(8'h00, 8'h80);
        for (int i = 0; i < 15; i++) push(8'h3C, 8'h00);
        push(8'h01, 8'h01);
        tick(2);
        flush();
        drain("case_split");

        // Reset while a byte is stalled in SCAN; stream restarts from run 0.
        cnt_full = 1'b1;
        exp_dat(8'h00);
        push(8'h00, 8'h00);
        push(8'hFF, 8'h0F);
        tick(12);
        drain("case_pre_reset");
        rst = 1'b0;
        #2;
        chk_quiet("outputs_in_reset");
        tick(2);
        cnt_full = 1'b0;
        tick(1);
        chk_quiet("outputs_in_reset_late");
        rst = 1'b1;
        tick(1);
        exp_dat(8'hA5);
        exp_tok(8'h88, 1'b1);
        exp_dat(8'h00);
        exp_tok(8'h07, 1'b0);
        exp_done();
        push(8'hA5, 8'h00);
        push(8'h80, 8'h80);
        tick(2);
        flush();
        drain("case_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
